// File: rtl/apb_rw_scheduler_if.sv
// Request/grant bundle between the AXI read/write front ends and the shared APB engine scheduler.
// The master side raises requests and completions; the slave side (the scheduler) returns grants and status.
interface apb_rw_scheduler_if;
   logic rd_req;
   logic wr_req;
   logic rd_done;
   logic wr_done;
   logic rd_grant;
   logic wr_grant;
   logic busy;
   logic timeout;
   logic timeout_wr;

   modport master (
      output rd_req,
      output wr_req,
      output rd_done,
      output wr_done,
      input  rd_grant,
      input  wr_grant,
      input  busy,
      input  timeout,
      input  timeout_wr
   );

   modport slave (
      input  rd_req,
      input  wr_req,
      input  rd_done,
      input  wr_done,
      output rd_grant,
      output wr_grant,
      output busy,
      output timeout,
      output timeout_wr
   );
endinterface

// File: rtl/apb_rw_scheduler.sv
// Grants the single APB master engine to either the AXI read or write path, using weighted
// round-robin on contested arbitrations and a watchdog that reclaims a grant that never completes.
module apb_rw_scheduler #(
   parameter int unsigned RD_WEIGHT = 2,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   apb_rw_scheduler_if.slave   bus
);

   localparam int unsigned STREAK_W = $clog2(RD_WEIGHT + 1);
   localparam int unsigned WDOG_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          WDOG_EN  = (TIMEOUT > 0);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(RD_WEIGHT);
   localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_EN ? WDOG_W'(TIMEOUT - 1) : '0;
   localparam logic [WDOG_W-1:0]   WDOG_SAT   = WDOG_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_RD = 2'd1,
      GNT_WR = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   logic [WDOG_W-1:0]   wdog_q;
   logic [WDOG_W-1:0]   wdog_d;
   logic                rd_grant_q;
   logic                wr_grant_q;
   logic                timeout_q;
   logic                timeout_d;
   logic                timeout_wr_q;
   logic                timeout_wr_d;
   logic                wdog_expired;
   logic                contested;

   assign contested    = bus.rd_req && bus.wr_req;
   assign wdog_expired = WDOG_EN && (wdog_q == WDOG_LAST);

   // Next-state logic. Done always beats watchdog expiry in the same cycle.
   always_comb begin
      state_d      = state_q;
      streak_d     = streak_q;
      wdog_d       = wdog_q;
      timeout_d    = 1'b0;
      timeout_wr_d = timeout_wr_q;

      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (contested) begin
               if (streak_q < STREAK_MAX) begin
                  state_d  = GNT_RD;
                  streak_d = streak_q + 1'b1;
               end else begin
                  state_d  = GNT_WR;
                  streak_d = '0;
               end
            end else if (bus.rd_req) begin
               state_d = GNT_RD;
            end else if (bus.wr_req) begin
               state_d  = GNT_WR;
               streak_d = '0;
            end
         end

         GNT_RD: begin
            if (bus.rd_done) begin
               state_d = IDLE;
               wdog_d  = '0;
            end else if (wdog_expired) begin
               state_d      = IDLE;
               wdog_d       = '0;
               timeout_d    = 1'b1;
               timeout_wr_d = 1'b0;
            end else if (wdog_q != WDOG_SAT) begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         GNT_WR: begin
            if (bus.wr_done) begin
               state_d = IDLE;
               wdog_d  = '0;
            end else if (wdog_expired) begin
               state_d      = IDLE;
               wdog_d       = '0;
               timeout_d    = 1'b1;
               timeout_wr_d = 1'b1;
            end else if (wdog_q != WDOG_SAT) begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            wdog_d  = '0;
         end
      endcase
   end

   // Grants get their own flops decoded from the next state so they leave the block registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         streak_q     <= '0;
         wdog_q       <= '0;
         rd_grant_q   <= 1'b0;
         wr_grant_q   <= 1'b0;
         timeout_q    <= 1'b0;
         timeout_wr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         streak_q     <= streak_d;
         wdog_q       <= wdog_d;
         rd_grant_q   <= (state_d == GNT_RD);
         wr_grant_q   <= (state_d == GNT_WR);
         timeout_q    <= timeout_d;
         timeout_wr_q <= timeout_wr_d;
      end
   end

   assign bus.rd_grant   = rd_grant_q;
   assign bus.wr_grant   = wr_grant_q;
   assign bus.busy       = rd_grant_q | wr_grant_q;
   assign bus.timeout    = timeout_q;
   assign bus.timeout_wr = timeout_wr_q;

   a_grant_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_grant_q && wr_grant_q));

   a_streak_bounded : assert property (@(posedge clk) disable iff (!rst_n)
      streak_q <= STREAK_MAX);

endmodule

// File: tb/tb_apb_rw_scheduler.sv
// Scoreboard bench for apb_rw_scheduler: expected grant sides and timeouts are queued as stimulus
// is applied and retired by a monitor as the grants and timeout pulses appear.
module tb_apb_rw_scheduler;

   localparam int unsigned RD_WEIGHT = 2;
   localparam int unsigned TIMEOUT   = 8;

   logic clk = 1'b0;
   logic rst_n;

   apb_rw_scheduler_if bus ();

   apb_rw_scheduler #(
      .RD_WEIGHT (RD_WEIGHT),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int check_count = 0;
   int pass_count  = 0;
   bit grant_q[$];
   bit timeout_q[$];
   bit rd_prev = 1'b0;
   bit wr_prev = 1'b0;
   bit side;
   int held;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [31:0] outVec();
      return {27'd0, bus.rd_grant, bus.wr_grant, bus.busy, bus.timeout, bus.timeout_wr};
   endfunction

   task automatic applyStimulus(input bit rd, input bit wr);
      bus.rd_req = rd;
      bus.wr_req = wr;
   endtask

   task automatic expectGrant(input bit wr_side);
      grant_q.push_back(wr_side);
   endtask

   task automatic scoreGrant(input bit wr_side);
      checkOutput("sb_grant_expected", 32'(grant_q.size() != 0), 1);
      if (grant_q.size() != 0)
         checkOutput("sb_grant_side", 32'(wr_side), 32'(grant_q.pop_front()));
   endtask

   task automatic scoreTimeout(input bit wr_side);
      checkOutput("sb_timeout_expected", 32'(timeout_q.size() != 0), 1);
      if (timeout_q.size() != 0)
         checkOutput("sb_timeout_side", 32'(wr_side), 32'(timeout_q.pop_front()));
   endtask

   // Waits (bounded) for a grant; every caller expects it on the very next cycle.
   task automatic waitGrant(input string tag, output bit wr_side);
      int idle = 0;
      tick();
      while (!bus.busy && idle < 6) begin
         idle++;
         tick();
      end
      checkOutput({tag, "_seen"}, 32'(bus.busy), 1);
      checkOutput({tag, "_latency"}, idle, 0);
      wr_side = bus.wr_grant;
   endtask

   task automatic releaseGrant(input string tag, input bit wr_side, input bit rd_next, input bit wr_next);
      if (wr_side) bus.wr_done = 1'b1;
      else         bus.rd_done = 1'b1;
      applyStimulus(rd_next, wr_next);
      tick();
      bus.rd_done = 1'b0;
      bus.wr_done = 1'b0;
      checkOutput({tag, "_release"}, 32'(bus.busy), 0);
      checkOutput({tag, "_no_timeout"}, 32'(bus.timeout), 0);
   endtask

   always @(negedge clk) begin
      if (bus.rd_grant && !rd_prev) scoreGrant(1'b0);
      if (bus.wr_grant && !wr_prev) scoreGrant(1'b1);
      if (bus.timeout) scoreTimeout(bus.timeout_wr);
      rd_prev = bus.rd_grant;
      wr_prev = bus.wr_grant;
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      rst_n       = 1'b0;
      bus.rd_done = 1'b0;
      bus.wr_done = 1'b0;
      applyStimulus(1'b0, 1'b0);

      repeat (3) begin
         tick();
         checkOutput("reset_outputs", outVec(), 0);
      end
      rst_n = 1'b1;
      repeat (10) begin
         tick();
         checkOutput("idle_outputs", outVec(), 0);
      end

      // Single read, released after 5 granted cycles.
      expectGrant(1'b0);
      applyStimulus(1'b1, 1'b0);
      waitGrant("single_rd", side);
      checkOutput("single_rd_grant", 32'(bus.rd_grant), 1);
      applyStimulus(1'b0, 1'b0);
      repeat (4) begin
         tick();
         checkOutput("single_rd_hold", {30'd0, bus.rd_grant, bus.wr_grant}, 32'h2);
      end
      releaseGrant("single_rd", 1'b0, 1'b0, 1'b0);

      // Contested stream with weight 2: R,R,W,R,R,W.
      expectGrant(1'b0); expectGrant(1'b0); expectGrant(1'b1);
      expectGrant(1'b0); expectGrant(1'b0); expectGrant(1'b1);
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         waitGrant("contend", side);
         repeat (2) tick();
         releaseGrant("contend", side, i != 5, i != 5);
      end

      // Uncontested write clears the streak, so two more contests go to reads.
      expectGrant(1'b0);
      applyStimulus(1'b1, 1'b1);
      waitGrant("wreset_r1", side);
      tick();
      releaseGrant("wreset_r1", side, 1'b0, 1'b1);
      expectGrant(1'b1);
      waitGrant("wreset_w", side);
      applyStimulus(1'b1, 1'b1);
      tick();
      releaseGrant("wreset_w", side, 1'b1, 1'b1);
      expectGrant(1'b0);
      waitGrant("wreset_r2", side);
      tick();
      releaseGrant("wreset_r2", side, 1'b1, 1'b1);
      expectGrant(1'b0);
      waitGrant("wreset_r3", side);
      tick();
      releaseGrant("wreset_r3", side, 1'b0, 1'b0);

      // Write that never completes is reclaimed after TIMEOUT cycles.
      expectGrant(1'b1);
      timeout_q.push_back(1'b1);
      applyStimulus(1'b0, 1'b1);
      waitGrant("wdog", side);
      applyStimulus(1'b0, 1'b0);
      held = 0;
      while (bus.wr_grant && held < 20) begin
         held++;
         tick();
      end
      checkOutput("wdog_held_cycles", held, TIMEOUT);
      checkOutput("wdog_pulse", 32'(bus.timeout), 1);
      checkOutput("wdog_side", 32'(bus.timeout_wr), 1);
      checkOutput("wdog_idle", 32'(bus.busy), 0);
      tick();
      checkOutput("wdog_pulse_width", 32'(bus.timeout), 0);
      checkOutput("wdog_side_held", 32'(bus.timeout_wr), 1);

      // Done in the last allowed cycle wins over the watchdog.
      expectGrant(1'b1);
      applyStimulus(1'b0, 1'b1);
      waitGrant("wdone", side);
      applyStimulus(1'b0, 1'b0);
      repeat (7) tick();
      checkOutput("wdone_cycle8_granted", 32'(bus.wr_grant), 1);
      releaseGrant("wdone", 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("wdone_no_pulse", 32'(bus.timeout), 0);
      checkOutput("wdone_side_held", 32'(bus.timeout_wr), 1);

      // Stray completions are ignored.
      expectGrant(1'b0);
      applyStimulus(1'b1, 1'b0);
      waitGrant("stray", side);
      applyStimulus(1'b0, 1'b0);
      bus.wr_done = 1'b1;
      tick();
      bus.wr_done = 1'b0;
      checkOutput("stray_wr_done_rd_held", 32'(bus.rd_grant), 1);
      tick();
      checkOutput("stray_grants", {30'd0, bus.rd_grant, bus.wr_grant}, 32'h2);
      releaseGrant("stray", 1'b0, 1'b0, 1'b0);
      bus.rd_done = 1'b1;
      tick();
      bus.rd_done = 1'b0;
      checkOutput("idle_done_ignored", outVec(), 32'h1);
      tick();
      checkOutput("idle_done_still_idle", outVec(), 32'h1);

      // Reset pulled mid write grant drops everything at once.
      expectGrant(1'b1);
      applyStimulus(1'b0, 1'b1);
      waitGrant("rst_mid", side);
      applyStimulus(1'b0, 1'b0);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_async_drop", outVec(), 0);
      tick();
      checkOutput("rst_mid_held", outVec(), 0);
      rst_n = 1'b1;
      tick();
      checkOutput("rst_mid_after", outVec(), 0);

      // Arbitration resumes from a cleared streak.
      expectGrant(1'b0); expectGrant(1'b0); expectGrant(1'b1);
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         waitGrant("resume", side);
         tick();
         releaseGrant("resume", side, i != 2, i != 2);
      end

      repeat (3) tick();
      checkOutput("final_idle", 32'(bus.busy), 0);
      checkOutput("sb_grants_drained", grant_q.size(), 0);
      checkOutput("sb_timeouts_drained", timeout_q.size(), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/apb_rw_scheduler.md
# apb_rw_scheduler

Arbitration and sequencing controller that shares the single APB master engine of the AXI-to-APB bridge between the AXI read channel (AR) and the AXI write channel (AW+W). It takes a read request and a write request, grants the engine to exactly one of them, and holds that grant until the engine reports completion. Contested arbitrations use weighted round-robin, so neither direction starves. A watchdog reclaims the engine when a transaction never completes.

## Interface
Parameters:
- `RD_WEIGHT`, default 2: maximum consecutive contested arbitrations reads may win before one write is forced. Legal range 1..15; 1 gives strict alternation.
- `TIMEOUT`, default 256: maximum cycles a grant may be held without done. 0 disables the watchdog. Legal range 0..65535.

Ports:
- `clk` in, 1: clock. All state changes on its rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `rd_req` in, 1: read pending (arvalid seen, no read in flight).
- `wr_req` in, 1: write pending (awvalid and wvalid seen).
- `rd_done` in, 1: one-cycle pulse, read transaction fully returned on AXI R.
- `wr_done` in, 1: one-cycle pulse, write response accepted on AXI B.
- `rd_grant` out, 1: engine owned by read path. Registered.
- `wr_grant` out, 1: engine owned by write path. Registered.
- `busy` out, 1: either grant high.
- `timeout` out, 1: one-cycle pulse, grant reclaimed by watchdog.
- `timeout_wr` out, 1: side of the last timeout (1 = write). Holds its value until the next timeout.

## Operation
- States: IDLE, GNT_RD, GNT_WR. `rd_grant` = (state==GNT_RD); `wr_grant` = (state==GNT_WR). The grants are never high together.
- IDLE, no requests: stay in IDLE.
- IDLE, only rd_req: go to GNT_RD. `streak` is unchanged.
- IDLE, only wr_req: go to GNT_WR. `streak` is cleared to 0.
- IDLE, both requests (contested):
  - if streak < RD_WEIGHT: go to GNT_RD, streak += 1.
  - else: go to GNT_WR, streak = 0.
- `streak` width is $clog2(RD_WEIGHT+1). It never exceeds RD_WEIGHT, so it never wraps.
- GNT_RD: rd_done → IDLE. GNT_WR: wr_done → IDLE.
- Ignored inputs, with no state effect:
  - done for the non-granted side;
  - done while in IDLE;
  - request changes while granted.
- Watchdog (TIMEOUT>0):
  - `wdog` is cleared on entry to GNT_x and increments each granted cycle.
  - If `wdog` == TIMEOUT-1 and the matching done is low, the next edge goes to IDLE, pulses `timeout`, and loads `timeout_wr`.
  - `wdog` width is $clog2(TIMEOUT+1) and saturates.
- Done and watchdog expiry in the same cycle: done wins, no timeout pulse.
- A timed-out side is not penalized. It re-arbitrates normally if still requesting.

## Timing
- Reset values: state IDLE; rd_grant, wr_grant, busy, timeout, timeout_wr all 0; streak 0; wdog 0.
- Reset asserted mid-grant: grant drops asynchronously, with no done or timeout generated.
- Request latency: a request sampled in IDLE at edge N gives a grant high after edge N (1 cycle).
- Release: done sampled at edge M gives the grant low after edge M.
- Back-to-back transactions: IDLE occupies the cycle after M. The next grant rises after edge M+1, so there is a minimum 1-cycle gap between grants.
- Timeout: the grant is held exactly TIMEOUT cycles. `timeout` is high for the single cycle following the release edge.
- `busy` is combinational from state, with no extra latency.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, release, no requests for 10 cycles. Required: all outputs 0 throughout.
- Single read: pulse rd_req, then rd_done 5 cycles after the grant. Required: rd_grant high 1 cycle after request, low 1 cycle after done. wr_grant stays 0.
- Weighted contention with RD_WEIGHT=2: hold rd_req=wr_req=1 and return done 3 cycles after each grant. Required grant order: R,R,W,R,R,W. One idle cycle between grants.
- Uncontested write resets the weight (RD_WEIGHT=2): contested R, then wr_req alone, then contested again. Required: W granted alone, then the next two contests go to R.
- Watchdog with TIMEOUT=8: grant the write and never assert wr_done. Required: wr_grant high exactly 8 cycles, then `timeout` one-cycle pulse with timeout_wr=1 and state IDLE. Repeat with wr_done in the 8th granted cycle. Required: normal release, no timeout pulse.
- Stray and async events: wr_done during GNT_RD is ignored and rd_grant holds. rst_n pulled low mid-GNT_WR: wr_grant low immediately, no timeout pulse. After release, arbitration resumes with streak=0.
